uart_tx_buffered: RTL and testbench

- Buffered UART transmitter.
- Accepts bytes through a valid/ready handshake into an internal FIFO, then serialises them onto the TX line as 8N1 frames, LSB first, line idle high.
- Sits between the processor output and the TX pin. Lets the processor emit bursts without waiting for each byte to finish on the line.
- Is the transmit-side counterpart of the receive path that feeds the processor.

---
 rtl/uart_tx_buffered_pkg.sv | 18 +
 rtl/uart_tx_buffered_fifo.sv | 65 ++++++
 rtl/uart_tx_buffered.sv | 153 +++++++++++++++
 tb/tb_uart_tx_buffered.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_tx_buffered_pkg.sv
// Shared UART definitions: FSM state encodings and frame constants, common to the TX and RX paths.
package uart_tx_buffered_pkg;

  localparam int unsigned DATA_BITS = 8;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } tx_state_t;

  function automatic logic even_parity(input logic [DATA_BITS-1:0] i_data);
    return ^i_data;
  endfunction

endpackage

// File: rtl/uart_tx_buffered_fifo.sv
// Single-clock synchronous FIFO with first-word-fall-through read data.
module byte_fifo #(
  parameter int unsigned WIDTH      = 8,
  parameter int unsigned DEPTH_LOG2 = 4
) (
  input  logic                  i_Clock,
  input  logic                  i_Reset,
  input  logic                  wr_en,
  input  logic [WIDTH-1:0]      wr_data,
  input  logic                  rd_en,
  output logic [WIDTH-1:0]      rd_data,
  output logic [DEPTH_LOG2:0]   count,
  output logic                  full,
  output logic                  empty
);

  localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] FULL_CNT = {1'b1, {DEPTH_LOG2{1'b0}}};

  logic [WIDTH-1:0]      r_mem [DEPTH];
  logic [DEPTH_LOG2-1:0] r_wr_ptr;
  logic [DEPTH_LOG2-1:0] r_rd_ptr;
  logic [DEPTH_LOG2:0]   r_count;
  logic [DEPTH_LOG2:0]   w_count_next;
  logic                  r_full;
  logic                  w_wr;
  logic                  w_rd;

  assign w_wr = wr_en && !r_full;
  assign w_rd = rd_en && (r_count != '0);

  always_comb begin
    w_count_next = r_count;
    if (w_wr && !w_rd) begin
      w_count_next = r_count + 1'b1;
    end else if (w_rd && !w_wr) begin
      w_count_next = r_count - 1'b1;
    end
  end

  // Full is registered from the next count so it is valid at the start of every cycle.
  always_ff @(posedge i_Clock) begin
    if (i_Reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_full   <= 1'b0;
    end else begin
      if (w_wr) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_rd) r_rd_ptr <= r_rd_ptr + 1'b1;
      r_count <= w_count_next;
      r_full  <= (w_count_next == FULL_CNT);
    end
  end

  always_ff @(posedge i_Clock) begin
    if (w_wr) r_mem[r_wr_ptr] <= wr_data;
  end

  assign rd_data = r_mem[r_rd_ptr];
  assign count   = r_count;
  assign full    = r_full;
  assign empty   = (r_count == '0);

endmodule

// File: rtl/uart_tx_buffered.sv
// Buffered 8N1 UART transmitter: byte FIFO feeding a registered serialiser.
// Define UART_TX_PARITY_EN to insert an even-parity bit after the data bits.
module uart_tx_buffered
  import uart_tx_buffered_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT    = 12,
  parameter int unsigned FIFO_DEPTH_LOG2 = 4
) (
  input  logic                       i_Clock,
  input  logic                       i_Reset,
  input  logic                       i_Tx_DV,
  input  logic [7:0]                 i_Tx_Byte,
  output logic                       o_Ready,
  output logic                       o_Tx_Serial,
  output logic                       o_Tx_Active,
  output logic                       o_Tx_Done,
  output logic [FIFO_DEPTH_LOG2:0]   o_Fifo_Count
);

  localparam int unsigned CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] LAST_CLK = CNT_W'(CLKS_PER_BIT - 1);
  localparam int unsigned IDX_W = $clog2(DATA_BITS);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_BITS - 1);

  tx_state_t             r_state;
  tx_state_t             w_state_next;
  logic [CNT_W-1:0]      r_clk_cnt;
  logic [IDX_W-1:0]      r_bit_idx;
  logic [DATA_BITS-1:0]  r_shift;
  logic                  w_bit_end;
  logic                  w_pop;
  logic [DATA_BITS-1:0]  w_head;
  logic                  w_empty;
  logic                  w_full;
  logic                  w_serial;
  logic                  w_active;
  logic                  w_done;
  logic                  r_Tx_Serial;
  logic                  r_Tx_Active;
  logic                  r_Tx_Done;
`ifdef UART_TX_PARITY_EN
  logic                  r_parity;
`endif

  byte_fifo #(
    .WIDTH      (DATA_BITS),
    .DEPTH_LOG2 (FIFO_DEPTH_LOG2)
  ) u_fifo (
    .i_Clock (i_Clock),
    .i_Reset (i_Reset),
    .wr_en   (i_Tx_DV && o_Ready),
    .wr_data (i_Tx_Byte),
    .rd_en   (w_pop),
    .rd_data (w_head),
    .count   (o_Fifo_Count),
    .full    (w_full),
    .empty   (w_empty)
  );

  assign o_Ready   = !w_full;
  assign w_bit_end = (r_clk_cnt == LAST_CLK);

  always_comb begin
    w_state_next = r_state;
    w_pop        = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (!w_empty) begin
          w_pop        = 1'b1;
          w_state_next = ST_START;
        end
      end
      ST_START: if (w_bit_end) w_state_next = ST_DATA;
      ST_DATA: begin
        if (w_bit_end && (r_bit_idx == LAST_IDX)) begin
`ifdef UART_TX_PARITY_EN
          w_state_next = ST_PARITY;
`else
          w_state_next = ST_STOP;
`endif
        end
      end
`ifdef UART_TX_PARITY_EN
      ST_PARITY: if (w_bit_end) w_state_next = ST_STOP;
`endif
      // Chaining straight into START keeps back-to-back frames gapless.
      ST_STOP: begin
        if (w_bit_end) begin
          if (!w_empty) begin
            w_pop        = 1'b1;
            w_state_next = ST_START;
          end else begin
            w_state_next = ST_IDLE;
          end
        end
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    w_serial = 1'b1;
    w_active = (r_state != ST_IDLE);
    w_done   = (r_state == ST_STOP) && w_bit_end;
    case (r_state)
      ST_START:  w_serial = 1'b0;
      ST_DATA:   w_serial = r_shift[0];
`ifdef UART_TX_PARITY_EN
      ST_PARITY: w_serial = r_parity;
`endif
      default:   w_serial = 1'b1;
    endcase
  end

  always_ff @(posedge i_Clock) begin
    if (i_Reset) begin
      r_state     <= ST_IDLE;
      r_clk_cnt   <= '0;
      r_bit_idx   <= '0;
      r_shift     <= '0;
      r_Tx_Serial <= 1'b1;
      r_Tx_Active <= 1'b0;
      r_Tx_Done   <= 1'b0;
`ifdef UART_TX_PARITY_EN
      r_parity    <= 1'b0;
`endif
    end else begin
      r_state     <= w_state_next;
      r_Tx_Serial <= w_serial;
      r_Tx_Active <= w_active;
      r_Tx_Done   <= w_done;
      if (w_pop) begin
        r_shift   <= w_head;
        r_clk_cnt <= '0;
        r_bit_idx <= '0;
`ifdef UART_TX_PARITY_EN
        r_parity  <= even_parity(w_head);
`endif
      end else if (r_state != ST_IDLE) begin
        r_clk_cnt <= w_bit_end ? '0 : r_clk_cnt + 1'b1;
        if ((r_state == ST_DATA) && w_bit_end) begin
          r_shift   <= r_shift >> 1;
          r_bit_idx <= r_bit_idx + 1'b1;
        end
      end
    end
  end

  assign o_Tx_Serial = r_Tx_Serial;
  assign o_Tx_Active = r_Tx_Active;
  assign o_Tx_Done   = r_Tx_Done;

endmodule

// File: tb/tb_uart_tx_buffered.sv
// Directed self-checking bench for uart_tx_buffered; a negedge line monitor decodes frames.
module tb_uart_tx_buffered;

  localparam int CPB = 12;
`ifdef UART_TX_PARITY_EN
  localparam int PAR = 1;
`else
  localparam int PAR = 0;
`endif
  localparam int FRAME_CYC = (10 + PAR) * CPB;
  localparam int LAST_J    = 9 + PAR;

  logic       clk = 1'b0;
  logic       rst;
  logic       dv;
  logic [7:0] tx_byte;
  logic       ready;
  logic       serial;
  logic       active;
  logic       done;
  logic [4:0] fcount;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  logic [7:0] rx_q[$];
  int         start_q[$];
  logic       stop_q[$];
  logic       par_q[$];
  int         done_q[$];
  int         mbad = 0;

  uart_tx_buffered #(
    .CLKS_PER_BIT    (CPB),
    .FIFO_DEPTH_LOG2 (4)
  ) dut (
    .i_Clock      (clk),
    .i_Reset      (rst),
    .i_Tx_DV      (dv),
    .i_Tx_Byte    (tx_byte),
    .o_Ready      (ready),
    .o_Tx_Serial  (serial),
    .o_Tx_Active  (active),
    .o_Tx_Done    (done),
    .o_Fifo_Count (fcount)
  );

  initial forever #5 clk = ~clk;
  initial forever begin
    @(posedge clk);
    cyc++;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  task automatic wait_cyc(input int t);
    while (cyc < t) @(negedge clk);
  endtask

  task automatic clear_q();
    rx_q.delete();
    start_q.delete();
    stop_q.delete();
    par_q.delete();
    done_q.delete();
  endtask

  // Line monitor: samples mid-bit relative to the observed falling edge.
  initial begin
    bit         mbusy = 0;
    int         mstart = 0;
    int         mj = 0;
    logic [7:0] mbyte = '0;
    logic       mpar = 1'b0;
    forever begin
      @(negedge clk);
      if (done) done_q.push_back(cyc);
      if (rst) begin
        mbusy = 0;
      end else if (!mbusy) begin
        if (!serial) begin
          mbusy  = 1;
          mstart = cyc;
          mj     = 0;
          mpar   = 1'b0;
        end
      end else if (cyc == mstart + CPB * mj + CPB / 2) begin
        if (mj == 0) begin
          if (serial) mbad++;
        end else if (mj <= 8) begin
          mbyte[mj-1] = serial;
        end else if (mj < LAST_J) begin
          mpar = serial;
        end else begin
          rx_q.push_back(mbyte);
          start_q.push_back(mstart);
          stop_q.push_back(serial);
          par_q.push_back(mpar);
          mbusy = 0;
        end
        mj++;
      end
    end
  end

  initial begin
    int n;
    int peak;
    bit acc;
    rst     = 1'b1;
    dv      = 1'b0;
    tx_byte = '0;
    repeat (3) @(negedge clk);
    check("rst_serial", serial, 1);
    check("rst_active", active, 0);
    check("rst_done",   done,   0);
    check("rst_ready",  ready,  1);
    check("rst_count",  fcount, 0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Single byte 0xA5
    clear_q();
    @(negedge clk);
    n = cyc + 1; dv = 1'b1; tx_byte = 8'hA5;
    @(negedge clk);
    dv = 1'b0; tx_byte = 8'hFF;
    check("single_count", fcount, 1);
    wait_cyc(n + 1);
    check("pre_start_serial", serial, 1);
    check("pre_start_active", active, 0);
    wait_cyc(n + 2);
    check("start_serial", serial, 0);
    check("start_active", active, 1);
    wait_cyc(n + 13);
    check("start_last", serial, 0);
    wait_cyc(n + 14);
    check("bit0_first", serial, 1);
    wait_cyc(n + 1 + FRAME_CYC);
    check("done_pulse",  done,   1);
    check("done_active", active, 1);
    wait_cyc(n + 2 + FRAME_CYC);
    check("post_done",   done,   0);
    check("post_active", active, 0);
    check("post_serial", serial, 1);
    wait_cyc(n + FRAME_CYC + 10);
    check("single_nframes", rx_q.size(), 1);
    check("single_ndone",   done_q.size(), 1);
    if (rx_q.size() == 1 && done_q.size() == 1) begin
      check("single_byte",  rx_q[0], 8'hA5);
      check("single_start", start_q[0], n + 2);
      check("single_stop",  stop_q[0], 1);
      check("single_done",  done_q[0], n + 1 + FRAME_CYC);
    end

    // Burst of three bytes on consecutive cycles
    clear_q();
    peak = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (i == 0) n = cyc + 1;
      if (i == 2) check("wr_pop_same", fcount, 1);
      if (int'(fcount) > peak) peak = int'(fcount);
      dv = 1'b1; tx_byte = 8'(i + 1);
    end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      dv = 1'b0;
      if (int'(fcount) > peak) peak = int'(fcount);
    end
    check("burst_peak", peak, 2);
    wait_cyc(n + 2 + 3 * FRAME_CYC + 5);
    check("burst_nframes", rx_q.size(), 3);
    check("burst_ndone",   done_q.size(), 3);
    if (rx_q.size() == 3 && done_q.size() == 3) begin
      for (int k = 0; k < 3; k++) begin
        check("burst_byte",  rx_q[k], k + 1);
        check("burst_start", start_q[k], n + 2 + k * FRAME_CYC);
        check("burst_done",  done_q[k], n + 1 + (k + 1) * FRAME_CYC);
      end
    end

    // 18 writes into a 16-deep FIFO while the first frame transmits
    clear_q();
    for (int i = 0; i < 18; i++) begin
      @(negedge clk);
      if (i == 0) n = cyc + 1;
      if (i == 16) check("ready_before_full", ready, 1);
      if (i == 17) check("ready_full", ready, 0);
      dv = 1'b1; tx_byte = 8'(i);
    end
    @(negedge clk);
    tx_byte = 8'h55;
    check("full_count", fcount, 16);
    check("full_ready", ready, 0);
    acc = 0;
    for (int k = 0; k < 400 && !acc; k++) begin
      if (ready) begin
        acc = 1;
        check("count_after_pop", fcount, 15);
        @(negedge clk);
        dv = 1'b0;
        check("count_refill", fcount, 16);
        check("ready_refill", ready, 0);
      end else begin
        @(negedge clk);
      end
    end
    dv = 1'b0;
    check("refill_timeout", acc, 1);
    check("refill_time", cyc, n + 2 + FRAME_CYC);
    wait_cyc(n + 2 + 18 * FRAME_CYC + 5);
    check("full_nframes", rx_q.size(), 18);
    if (rx_q.size() == 18) begin
      for (int k = 0; k < 18; k++) begin
        check("full_byte",  rx_q[k], (k < 17) ? k : 8'h55);
        check("full_start", start_q[k], n + 2 + k * FRAME_CYC);
        check("full_stop",  stop_q[k], 1);
      end
    end

    // Reset in the middle of data bit 3
    clear_q();
    @(negedge clk);
    n = cyc + 1; dv = 1'b1; tx_byte = 8'h96;
    @(negedge clk);
    dv = 1'b0;
    @(negedge clk);
    dv = 1'b1; tx_byte = 8'h11;
    @(negedge clk);
    dv = 1'b0;
    wait_cyc(n + 2 + 4 * CPB + 5);
    rst = 1'b1;
    @(negedge clk);
    check("midrst_serial", serial, 1);
    check("midrst_count",  fcount, 0);
    check("midrst_ready",  ready,  1);
    check("midrst_active", active, 0);
    #1 rst = 1'b0;
    wait_cyc(cyc + FRAME_CYC);
    check("midrst_nframes", rx_q.size(), 0);
    check("midrst_ndone",   done_q.size(), 0);
    check("midrst_line",    serial, 1);
    @(negedge clk);
    n = cyc + 1; dv = 1'b1; tx_byte = 8'h3C;
    @(negedge clk);
    dv = 1'b0;
    wait_cyc(n + 2 + FRAME_CYC + 5);
    check("after_rst_nframes", rx_q.size(), 1);
    if (rx_q.size() == 1) begin
      check("after_rst_byte",  rx_q[0], 8'h3C);
      check("after_rst_start", start_q[0], n + 2);
    end

`ifdef UART_TX_PARITY_EN
    clear_q();
    @(negedge clk);
    n = cyc + 1; dv = 1'b1; tx_byte = 8'h07;
    @(negedge clk);
    tx_byte = 8'h03;
    @(negedge clk);
    dv = 1'b0;
    wait_cyc(n + 2 + 2 * FRAME_CYC + 5);
    check("par_nframes", rx_q.size(), 2);
    if (rx_q.size() == 2) begin
      check("par_byte0",   rx_q[0], 8'h07);
      check("par_bit0",    par_q[0], 1);
      check("par_byte1",   rx_q[1], 8'h03);
      check("par_bit1",    par_q[1], 0);
      check("par_spacing", start_q[1] - start_q[0], 132);
    end
`endif

    check("start_bit_glitches", mbad, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
